// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline stage with a valid/ready handshake, a 2-entry skid buffer,
// NORMAL/STALL/FLUSH flow control and a saturating bubble counter.
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        flow_op,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [1:0] OP_NORMAL = 2'b00;
  localparam logic [1:0] OP_FLUSH  = 2'b10;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data, main_data_nxt, skid_data, skid_data_nxt;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;
  logic              normal, flush, acc, pop;

  // 2'b11 decodes as neither NORMAL nor FLUSH, so it behaves as STALL.
  assign normal = (flow_op == OP_NORMAL);
  assign flush  = (flow_op == OP_FLUSH);

  // in_ready is also gated by rst so upstream sees no acceptance while reset is held.
  assign in_ready  = normal && (state != TWO) && !rst;
  assign out_valid = normal && (state != EMPTY);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data = main_data;
  assign out_ctrl = main_ctrl;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_nxt     = state;
    main_data_nxt = main_data;
    main_ctrl_nxt = main_ctrl;
    skid_data_nxt = skid_data;
    skid_ctrl_nxt = skid_ctrl;

    if (flush) begin
      state_nxt     = EMPTY;
      main_data_nxt = '0;
      main_ctrl_nxt = '0;
      skid_data_nxt = '0;
      skid_ctrl_nxt = '0;
    end else if (normal) begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state_nxt     = ONE;
            main_data_nxt = in_data;
            main_ctrl_nxt = in_ctrl;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_data_nxt = in_data;
            main_ctrl_nxt = in_ctrl;
          end else if (acc) begin
            state_nxt     = TWO;
            skid_data_nxt = in_data;
            skid_ctrl_nxt = in_ctrl;
          end else if (pop) begin
            state_nxt     = EMPTY;
            main_data_nxt = '0;
            main_ctrl_nxt = '0;
          end
        end
        TWO: begin
          if (pop) begin
            state_nxt     = ONE;
            main_data_nxt = skid_data;
            main_ctrl_nxt = skid_ctrl;
            skid_data_nxt = '0;
            skid_ctrl_nxt = '0;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state     <= state_nxt;
      main_data <= main_data_nxt;
      main_ctrl <= main_ctrl_nxt;
      skid_data <= skid_data_nxt;
      skid_ctrl <= skid_ctrl_nxt;
    end
  end

  // Bubble counter counts idle NORMAL cycles only; FLUSH and STALL leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (normal && (state == EMPTY) && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: a vector table for streaming, skid, stall and
// flush behaviour, plus hand-written sequences for counter saturation and async reset.
module tb_ex_mem_pipe;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 9;
  localparam int CNT_W  = 4;

  localparam logic [1:0] N  = 2'b00;
  localparam logic [1:0] S  = 2'b01;
  localparam logic [1:0] F  = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        flow_op;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  int errors = 0;
  int checks = 0;

  ex_mem_pipe #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flow_op    (flow_op),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]        flow;
    logic              iv;
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic              ordy;
    logic              e_ir;
    logic              e_ov;
    logic [DATA_W-1:0] e_d;
    logic [CTRL_W-1:0] e_c;
    logic [CNT_W-1:0]  e_b;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] flow, input logic iv, input logic [31:0] d,
                              input logic [8:0] c, input logic ordy, input logic e_ir,
                              input logic e_ov, input logic [31:0] e_d, input logic [8:0] e_c,
                              input logic [3:0] e_b);
    vec_t v;
    v.flow = flow; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_d = e_d; v.e_c = e_c; v.e_b = e_b;
    return v;
  endfunction

  task automatic drive(input logic [1:0] flow, input logic iv, input logic [31:0] d,
                       input logic [8:0] c, input logic ordy);
    flow_op = flow; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each vector: inputs held for one cycle; expected outputs sampled at the
    // falling edge of that cycle, before the rising edge that consumes them.
    // T2 streaming
    vecs.push_back(mk(N, 1, 32'h11, 9'h011, 1, 1, 0, 32'h0,  9'h000, 4'd0));
    vecs.push_back(mk(N, 1, 32'h22, 9'h022, 1, 1, 1, 32'h11, 9'h011, 4'd1));
    vecs.push_back(mk(N, 1, 32'h33, 9'h033, 1, 1, 1, 32'h22, 9'h022, 4'd1));
    vecs.push_back(mk(N, 0, 32'h0,  9'h000, 1, 1, 1, 32'h33, 9'h033, 4'd1));
    vecs.push_back(mk(N, 0, 32'h0,  9'h000, 0, 1, 0, 32'h0,  9'h000, 4'd1));
    // T3 skid absorbs the beat accepted while out_ready is low
    vecs.push_back(mk(N, 1, 32'hA1, 9'h0A1, 0, 1, 0, 32'h0,  9'h000, 4'd2));
    vecs.push_back(mk(N, 1, 32'hA2, 9'h0A2, 0, 1, 1, 32'hA1, 9'h0A1, 4'd3));
    vecs.push_back(mk(N, 1, 32'hA3, 9'h0A3, 0, 0, 1, 32'hA1, 9'h0A1, 4'd3));
    vecs.push_back(mk(N, 0, 32'h0,  9'h000, 1, 0, 1, 32'hA1, 9'h0A1, 4'd3));
    vecs.push_back(mk(N, 0, 32'h0,  9'h000, 1, 1, 1, 32'hA2, 9'h0A2, 4'd3));
    vecs.push_back(mk(N, 0, 32'h0,  9'h000, 0, 1, 0, 32'h0,  9'h000, 4'd3));
    // T4 stall in TWO, including the 2'b11 encoding
    vecs.push_back(mk(N,  1, 32'hB1, 9'h0B1, 0, 1, 0, 32'h0,  9'h000, 4'd4));
    vecs.push_back(mk(N,  1, 32'hB2, 9'h0B2, 0, 1, 1, 32'hB1, 9'h0B1, 4'd5));
    vecs.push_back(mk(S,  1, 32'hC1, 9'h0C1, 1, 0, 0, 32'hB1, 9'h0B1, 4'd5));
    vecs.push_back(mk(S,  1, 32'hC2, 9'h0C2, 1, 0, 0, 32'hB1, 9'h0B1, 4'd5));
    vecs.push_back(mk(S3, 1, 32'hC3, 9'h0C3, 1, 0, 0, 32'hB1, 9'h0B1, 4'd5));
    vecs.push_back(mk(N,  0, 32'h0,  9'h000, 1, 0, 1, 32'hB1, 9'h0B1, 4'd5));
    vecs.push_back(mk(N,  0, 32'h0,  9'h000, 1, 1, 1, 32'hB2, 9'h0B2, 4'd5));
    vecs.push_back(mk(N,  0, 32'h0,  9'h000, 0, 1, 0, 32'h0,  9'h000, 4'd5));
    // T5 flush from TWO with all ctrl bits set, concurrent beat 0xBB discarded
    vecs.push_back(mk(N, 1, 32'hD1, 9'h1FF, 0, 1, 0, 32'h0,  9'h000, 4'd6));
    vecs.push_back(mk(N, 1, 32'hD2, 9'h1FF, 0, 1, 1, 32'hD1, 9'h1FF, 4'd7));
    vecs.push_back(mk(F, 1, 32'hBB, 9'h1FF, 1, 0, 0, 32'hD1, 9'h1FF, 4'd7));
    vecs.push_back(mk(N, 0, 32'h0,  9'h000, 0, 1, 0, 32'h0,  9'h000, 4'd7));
    vecs.push_back(mk(N, 0, 32'h0,  9'h000, 1, 1, 0, 32'h0,  9'h000, 4'd8));

    // Reset state
    rst = 1'b1;
    drive(N, 0, 32'h0, 9'h0, 0);
    #1;
    check("rst_in_ready",   64'(in_ready),   64'd0);
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_out_data",   64'(out_data),   64'd0);
    check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    @(posedge clk);
    tick();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].flow, vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy);
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i),   64'(in_ready),   64'(vecs[i].e_ir));
      check($sformatf("v%0d_out_valid", i),  64'(out_valid),  64'(vecs[i].e_ov));
      check($sformatf("v%0d_out_data", i),   64'(out_data),   64'(vecs[i].e_d));
      check($sformatf("v%0d_out_ctrl", i),   64'(out_ctrl),   64'(vecs[i].e_c));
      check($sformatf("v%0d_bubble_cnt", i), 64'(bubble_cnt), 64'(vecs[i].e_b));
      tick();
    end

    // T6 counter saturates at 15 and survives a FLUSH
    drive(N, 0, 32'h0, 9'h0, 0);
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    check("t6_saturated", 64'(bubble_cnt), 64'd15);
    tick();
    drive(F, 0, 32'h0, 9'h0, 0);
    tick();
    @(negedge clk);
    check("t6_after_flush", 64'(bubble_cnt), 64'd15);
    tick();

    // T1 async reset while in TWO, no clock edge needed
    drive(N, 1, 32'hE1, 9'h0E1, 0);
    tick();
    drive(N, 1, 32'hE2, 9'h0E2, 0);
    tick();
    drive(N, 0, 32'h0, 9'h0, 1);
    @(negedge clk);
    check("t1_pre_two_ready", 64'(in_ready), 64'd0);
    check("t1_pre_head",      64'(out_data), 64'hE1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_out_valid",  64'(out_valid),  64'd0);
    check("t1_out_data",   64'(out_data),   64'd0);
    check("t1_out_ctrl",   64'(out_ctrl),   64'd0);
    check("t1_bubble_cnt", 64'(bubble_cnt), 64'd0);
    check("t1_in_ready",   64'(in_ready),   64'd0);
    tick();
    rst = 1'b0;
    drive(N, 1, 32'hF1, 9'h0F1, 1);
    @(negedge clk);
    check("t1_post_in_ready",  64'(in_ready),  64'd1);
    check("t1_post_out_valid", 64'(out_valid), 64'd0);
    tick();
    drive(N, 0, 32'h0, 9'h0, 1);
    @(negedge clk);
    check("t1_post_beat_valid", 64'(out_valid), 64'd1);
    check("t1_post_beat_data",  64'(out_data),  64'hF1);
    check("t1_post_bubble",     64'(bubble_cnt), 64'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
